pattern_detector: RTL

Parametrised serial bit-pattern detector: the next-generation sequence detector, with a run-time programmable pattern up to MAX_LEN bits, selectable overlapping/non-overlapping detection, input qualification and a saturating match counter. It sits on a 1-bit serial data path and flags each completed pattern occurrence with a registered one-cycle pulse. Reset defaults reproduce the legacy fixed "1011" overlapping detector.

---
 rtl/pattern_detector_pkg.sv | 26 ++
 rtl/sat_counter.sv | 36 +++
 rtl/pattern_detector.sv | 107 ++++++++++
 3 files changed

// File: rtl/pattern_detector_pkg.sv
// rtl/pattern_detector_pkg.sv - shared defaults and helpers for the serial pattern detector
package pattern_detector_pkg;

  // Reset defaults reproduce the legacy fixed "1011" overlapping detector.
  localparam int          PD_MAX_LEN     = 8;
  localparam int          PD_CNT_W       = 16;
  localparam logic [7:0]  PD_DEF_PATTERN = 8'b0000_1011;
  localparam int          PD_DEF_LEN     = 4;
  localparam bit          PD_DEF_OVERLAP = 1'b1;

  // Width needed to hold a length/fill value in the range 0..max_len.
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Mask with the low len bits set; callers cast down to their pattern width.
  function automatic logic [63:0] len_mask(input int unsigned len);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear over increment
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over increment; increment sticks at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pattern_detector.sv
// rtl/pattern_detector.sv - programmable serial bit-pattern detector with match counter
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int                 MAX_LEN     = PD_MAX_LEN,
  parameter int                 CNT_W       = PD_CNT_W,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(PD_DEF_PATTERN),
  parameter int                 DEF_LEN     = PD_DEF_LEN,
  parameter bit                 DEF_OVERLAP = PD_DEF_OVERLAP,
  localparam int                LEN_W       = calc_len_w(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sequence_in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               detector_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  // The oldest bit of a full MAX_LEN window is never compared again, so
  // only MAX_LEN-1 history bits are kept; the window adds the incoming bit.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               det_q, det_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               load_ok;
  logic               beat;
  logic               match;

  assign load_ok  = cfg_load && (cfg_len != '0) && (cfg_len <= LEN_MAX);
  assign beat     = in_valid && !load_ok;
  assign window   = {hist_q, sequence_in};
  assign mask     = MAX_LEN'(len_mask(32'(len_q)));
  assign fill_inc = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
  assign match    = beat && ((window & mask) == (pattern_q & mask)) && (fill_inc >= len_q);

  // Next-state: load/reject handling, history shift and fill tracking.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    det_d     = match;
    err_d     = cfg_load && !load_ok;
    if (load_ok) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (beat) begin
      hist_d = window[MAX_LEN-2:0];
      fill_d = (match && !overlap_q) ? '0 : fill_inc;
    end
  end

  // State registers; reset restores the legacy default configuration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      det_q     <= det_d;
      err_q     <= err_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (match),
    .clr   (count_clr || load_ok),
    .count (match_count)
  );

  assign detector_out = det_q;
  assign cfg_err      = err_q;

endmodule
